shift_add_mult_seq: RTL and testbench

//   Sequential unsigned shift-and-add multiplier controller; sits directly upstream
//   of the registered 17-bit ripple-carry adder stage.

---
 rtl/shift_add_mult_seq.sv | 134 +++++++++++++
 tb/tb_shift_add_mult_seq.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_seq.sv
// Sequential unsigned shift-and-add multiplier controller.
// Drives an external registered adder and accumulates its sum as the partial product.
module shift_add_mult_seq #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 2*WIDTH+1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [ACC_W-1:0]   add_a,
   output logic [ACC_W-1:0]   add_b,
   output logic               add_cin,
   output logic               add_en,
   input  logic [ACC_W-1:0]   add_q
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [WIDTH-1:0]     n_q, n_d;
   logic [ACC_W-1:0]     p_q, p_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic                 done_q, done_d;
   logic                 bit_set;
   logic                 last_idx;
   logic [ACC_W-1:0]     m_ext;

   assign bit_set  = n_q[idx_q];
   assign last_idx = (idx_q == IDX_W'(WIDTH-1));
   assign m_ext    = {{(ACC_W-WIDTH){1'b0}}, m_q};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         n_q     <= '0;
         p_q     <= '0;
         idx_q   <= '0;
         prod_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         n_q     <= n_d;
         p_q     <= p_d;
         idx_q   <= idx_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_SCAN;
         S_SCAN: begin
            if (bit_set)       state_d = S_WAIT;
            else if (last_idx) state_d = S_DONE;
         end
         S_WAIT: state_d = last_idx ? S_DONE : S_SCAN;
         S_DONE: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      m_d    = m_q;
      n_d    = n_q;
      p_d    = p_q;
      idx_d  = idx_q;
      prod_d = prod_q;
      done_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d   = multiplicand;
               n_d   = multiplier;
               p_d   = '0;
               idx_d = '0;
            end
         end
         S_SCAN: begin
            if (!bit_set && !last_idx) idx_d = idx_q + IDX_W'(1);
         end
         S_WAIT: begin
            p_d = add_q;
            if (!last_idx) idx_d = idx_q + IDX_W'(1);
         end
         S_DONE: begin
            done_d = 1'b1;
            prod_d = p_q[2*WIDTH-1:0];
         end
      endcase
   end

   // Adder operands are only meaningful while scanning/waiting; zero otherwise.
   always_comb begin
      busy   = 1'b0;
      add_en = 1'b0;
      add_a  = '0;
      add_b  = '0;
      unique case (state_q)
         S_IDLE: ;
         S_SCAN: begin
            busy   = 1'b1;
            add_en = bit_set;
            add_a  = p_q;
            add_b  = m_ext << idx_q;
         end
         S_WAIT: begin
            busy  = 1'b1;
            add_a = p_q;
            add_b = m_ext << idx_q;
         end
         S_DONE: busy = 1'b1;
      endcase
   end

   assign add_cin = 1'b0;
   assign done    = done_q;
   assign product = prod_q;

   a_no_ovf: assert property (@(posedge clk) disable iff (reset)
      (state_q == S_WAIT) |-> !add_q[ACC_W-1]);

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Randomized self-checking bench for shift_add_mult_seq with an attached
// registered adder and an arithmetic reference model.
module tb_shift_add_mult_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [16:0] add_a;
   logic [16:0] add_b;
   logic        add_cin;
   logic        add_en;
   logic [16:0] add_q;

   int total = 0;
   int bad   = 0;

   int          lat;
   int          en_cnt;
   int          busy_err;
   int          done_cnt;
   int          ovf;
   logic [15:0] prod_res;
   logic        busy_after;
   logic [15:0] prod_after;
   logic [16:0] qa[$];
   logic [16:0] qb[$];

   shift_add_mult_seq dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product),
      .add_a        (add_a),
      .add_b        (add_b),
      .add_cin      (add_cin),
      .add_en       (add_en),
      .add_q        (add_q)
   );

   always #5 clk = ~clk;

   // Downstream registered adder stage
   always_ff @(posedge clk) begin
      if (reset)       add_q <= '0;
      else if (add_en) add_q <= add_a + add_b + {16'd0, add_cin};
   end

   function automatic int popc(input logic [7:0] v);
      int c = 0;
      for (int i = 0; i < 8; i++) c += int'(v[i]);
      return c;
   endfunction

   // Called at a negedge; k counts negedges after the accepting edge.
   task automatic run_op(input logic [7:0] m, input logic [7:0] n,
                         input bit hold, input int pulse_at,
                         input int reset_at);
      qa.delete();
      qb.delete();
      lat = -1; en_cnt = 0; busy_err = 0; done_cnt = 0; ovf = 0;
      prod_res = 'x;
      multiplicand = m;
      multiplier   = n;
      start        = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (add_q[16]) ovf++;
         if (add_en) begin
            en_cnt++;
            qa.push_back(add_a);
            qb.push_back(add_b);
         end
         if (done) begin
            done_cnt++;
            if (lat < 0) begin
               lat = k;
               prod_res = product;
            end
            if (busy) busy_err++;
         end else if (lat < 0 && reset_at < 0 && !busy) begin
            busy_err++;
         end
         if (reset_at >= 0 && k == reset_at + 1) begin
            busy_after = busy;
            prod_after = product;
            reset = 1'b0;
         end
         if (reset_at >= 0 && k == reset_at) reset = 1'b1;
         if (pulse_at >= 0 && k == pulse_at) begin
            start = 1'b1;
            multiplicand = 8'h07;
            multiplier   = 8'h07;
         end else if (pulse_at >= 0 && k == pulse_at + 1) begin
            start = 1'b0;
         end
         if (lat >= 0 && reset_at < 0) break;
         if (reset_at >= 0 && k >= reset_at + 25) break;
      end
      if (!hold) start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b1;
      multiplicand = 8'h55;
      multiplier   = 8'hAA;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({busy, done, product, add_en, add_a, add_b, add_cin} !== '0) begin
         bad++;
         $display("FAIL reset_outputs busy=%b done=%b product=%h en=%b a=%h b=%h cin=%b want all 0",
                  busy, done, product, add_en, add_a, add_b, add_cin);
      end
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle busy=%b want 0", busy);
      end
   endtask

   task automatic test_zero;
      @(negedge clk);
      run_op(8'h00, 8'h00, 1'b0, -1, -1);
      total++;
      if (lat != 9 || prod_res !== 16'h0000 || en_cnt != 0) begin
         bad++;
         $display("FAIL zero_op lat=%0d prod=%h en=%0d want lat=9 prod=0000 en=0",
                  lat, prod_res, en_cnt);
      end
      total++;
      if (busy_err != 0) begin
         bad++;
         $display("FAIL zero_busy errors=%0d want 0", busy_err);
      end
   endtask

   task automatic test_max;
      @(negedge clk);
      run_op(8'hFF, 8'hFF, 1'b0, -1, -1);
      total++;
      if (lat != 17 || prod_res !== 16'hFE01 || en_cnt != 8) begin
         bad++;
         $display("FAIL max_op lat=%0d prod=%h en=%0d want lat=17 prod=fe01 en=8",
                  lat, prod_res, en_cnt);
      end
      total++;
      if (ovf != 0) begin
         bad++;
         $display("FAIL max_ovf add_q[16] high %0d cycles want 0", ovf);
      end
      @(negedge clk);
      total++;
      if (add_a !== '0 || add_b !== '0 || done !== 1'b0 || product !== 16'hFE01) begin
         bad++;
         $display("FAIL max_idle a=%h b=%h done=%b prod=%h want 0 0 0 fe01",
                  add_a, add_b, done, product);
      end
   endtask

   task automatic test_known;
      @(negedge clk);
      run_op(8'h0D, 8'h0B, 1'b0, -1, -1);
      total++;
      if (lat != 12 || prod_res !== 16'h008F || en_cnt != 3) begin
         bad++;
         $display("FAIL known_op lat=%0d prod=%h en=%0d want lat=12 prod=008f en=3",
                  lat, prod_res, en_cnt);
      end
      total++;
      if (qb.size() != 3 || qb[0] !== 17'h0D || qb[1] !== 17'h1A || qb[2] !== 17'h68) begin
         bad++;
         $display("FAIL known_add_b count=%0d got %h %h %h want 0d 1a 68",
                  qb.size(), qb.size() > 0 ? qb[0] : 17'h0,
                  qb.size() > 1 ? qb[1] : 17'h0, qb.size() > 2 ? qb[2] : 17'h0);
      end
   endtask

   task automatic test_ignore_start;
      @(negedge clk);
      run_op(8'h03, 8'h05, 1'b0, 3, -1);
      total++;
      if (lat != 11 || prod_res !== 16'h000F || done_cnt != 1) begin
         bad++;
         $display("FAIL ignore_start lat=%0d prod=%h dones=%0d want lat=11 prod=000f dones=1",
                  lat, prod_res, done_cnt);
      end
      repeat (20) begin
         @(negedge clk);
         total++;
         if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_queued busy=%b want 0", busy);
            break;
         end
      end
   endtask

   task automatic test_abort;
      @(negedge clk);
      run_op(8'h80, 8'h80, 1'b0, -1, 5);
      total++;
      if (busy_after !== 1'b0 || prod_after !== 16'h0000 || done_cnt != 0) begin
         bad++;
         $display("FAIL abort busy=%b prod=%h dones=%0d want busy=0 prod=0000 dones=0",
                  busy_after, prod_after, done_cnt);
      end
      @(negedge clk);
      run_op(8'h02, 8'h03, 1'b0, -1, -1);
      total++;
      if (lat != 11 || prod_res !== 16'h0006) begin
         bad++;
         $display("FAIL abort_restart lat=%0d prod=%h want lat=11 prod=0006",
                  lat, prod_res);
      end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      run_op(8'h04, 8'h02, 1'b1, -1, -1);
      total++;
      if (lat != 10 || prod_res !== 16'h0008) begin
         bad++;
         $display("FAIL b2b_first lat=%0d prod=%h want lat=10 prod=0008",
                  lat, prod_res);
      end
      run_op(8'h04, 8'h02, 1'b0, -1, -1);
      total++;
      if (lat != 10 || prod_res !== 16'h0008) begin
         bad++;
         $display("FAIL b2b_second lat=%0d prod=%h want lat=10 prod=0008",
                  lat, prod_res);
      end
   endtask

   task automatic test_random;
      logic [7:0]  m;
      logic [7:0]  n;
      logic [16:0] exp_a;
      int          j;
      int          err;
      for (int t = 0; t < 24; t++) begin
         m = 8'($urandom);
         n = 8'($urandom);
         repeat ($urandom_range(1, 3)) @(negedge clk);
         run_op(m, n, 1'b0, -1, -1);
         total++;
         if (lat != 9 + popc(n) || prod_res !== 16'(m * n) || en_cnt != popc(n)) begin
            bad++;
            $display("FAIL rand_op m=%h n=%h lat=%0d prod=%h en=%0d want lat=%0d prod=%h en=%0d",
                     m, n, lat, prod_res, en_cnt, 9 + popc(n), 16'(m * n), popc(n));
         end
         err = 0;
         j = 0;
         for (int i = 0; i < 8; i++) begin
            if (n[i]) begin
               exp_a = 17'(m * (n & 8'((1 << i) - 1)));
               if (j >= qa.size() || qa[j] !== exp_a || qb[j] !== 17'(m << i)) err++;
               j++;
            end
         end
         total++;
         if (err != 0 || ovf != 0 || busy_err != 0) begin
            bad++;
            $display("FAIL rand_operands m=%h n=%h operand_errs=%0d ovf=%0d busy_errs=%0d want 0 0 0",
                     m, n, err, ovf, busy_err);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      test_reset();
      test_zero();
      test_max();
      test_known();
      test_ignore_start();
      test_abort();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
